// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter (and receiver).
//   tx_state_e   - 3-bit encoding of the five transmitter states
//   LINE_IDLE / START_BIT / STOP_BIT - serial line levels
//   *_DEF        - default widths for the transmitter parameters
package uart_tx_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int PRESCALE_WIDTH_DEF = 6;
  localparam int BIT_CNT_WIDTH_DEF  = 4;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: datapath of the UART transmitter.
// Holds the latched frame data, the per-bit cycle counter, the data-bit index
// and the precomputed parity bit.
//   clk, rst_n     - clock, async active-low reset
//   load           - accept a new frame (latch data/parity/prescale, clear counters)
//   active         - frame in flight, cycle counter runs
//   data_step      - last cycle of a data bit, advance the bit index
//   p_data         - byte to latch on load
//   par_typ        - 0 even / 1 odd, used on load
//   prescale       - clocks per bit, 0 treated as 1, used on load
//   bit_done       - current bit has been driven for its full prescale period
//   last_bit       - bit index is at data_width-1
//   parity_bit     - latched parity bit
//   data_bit_next  - data bit selected by the index for the next cycle
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int data_width     = DATA_WIDTH_DEF,
  parameter int prescale_width = PRESCALE_WIDTH_DEF,
  parameter int bit_cnt_width  = BIT_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      active,
  input  logic                      data_step,
  input  logic [data_width-1:0]     p_data,
  input  logic                      par_typ,
  input  logic [prescale_width-1:0] prescale,
  output logic                      bit_done,
  output logic                      last_bit,
  output logic                      parity_bit,
  output logic                      data_bit_next
);

  localparam logic [prescale_width-1:0] CNT_ONE  = prescale_width'(1);
  localparam logic [bit_cnt_width-1:0]  IDX_ONE  = bit_cnt_width'(1);
  localparam logic [bit_cnt_width-1:0]  IDX_LAST = bit_cnt_width'(data_width - 1);

  logic [data_width-1:0]     data_q;
  logic [prescale_width-1:0] cnt_last_q;
  logic [prescale_width-1:0] cnt_q;
  logic [bit_cnt_width-1:0]  idx_q;
  logic [bit_cnt_width-1:0]  idx_d;
  logic                      parity_q;
  logic [data_width-1:0]     data_shifted;

  assign bit_done   = active && (cnt_q == cnt_last_q);
  assign last_bit   = (idx_q == IDX_LAST);
  assign parity_bit = parity_q;

  // Index saturates at the last data bit; it is only cleared by load.
  always_comb begin
    idx_d = idx_q;
    if (data_step && !last_bit) begin
      idx_d = idx_q + IDX_ONE;
    end
  end

  // Look-ahead bit so the TX_OUT flop can load the value it will show next cycle.
  assign data_shifted  = data_q >> idx_d;
  assign data_bit_next = data_shifted[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      cnt_last_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      parity_q   <= 1'b0;
    end else if (load) begin
      data_q     <= p_data;
      // Terminal count is P-1; prescale 0 behaves like 1.
      cnt_last_q <= (prescale == '0) ? '0 : (prescale - CNT_ONE);
      cnt_q      <= '0;
      idx_q      <= '0;
      parity_q   <= (^p_data) ^ par_typ;
    end else if (active) begin
      cnt_q <= bit_done ? '0 : (cnt_q + CNT_ONE);
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + LSB-first data + optional parity + stop.
//   CLK        - system clock
//   RST        - async active-low reset
//   P_DATA     - byte to send, sampled on acceptance
//   DATA_VALID - request strobe, accepted only while idle
//   PAR_EN     - append parity bit, sampled on acceptance
//   PAR_TYP    - 0 even / 1 odd parity, sampled on acceptance
//   prescale   - clocks per bit (0 treated as 1), sampled on acceptance
//   TX_OUT     - registered serial line, idles high
//   busy       - registered, high for the whole frame
//
// state     | meaning
// TX_IDLE   | line high, waiting for DATA_VALID
// TX_START  | driving start bit
// TX_DATA   | driving data bits LSB first
// TX_PARITY | driving parity bit
// TX_STOP   | driving stop bit
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int data_width     = DATA_WIDTH_DEF,
  parameter int prescale_width = PRESCALE_WIDTH_DEF,
  parameter int bit_cnt_width  = BIT_CNT_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [data_width-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [prescale_width-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  tx_state_e state_q;
  tx_state_e state_d;
  logic      par_en_q;
  logic      tx_d;
  logic      busy_d;
  logic      tx_q;
  logic      busy_q;

  logic load;
  logic active;
  logic data_step;
  logic bit_done;
  logic last_bit;
  logic parity_bit;
  logic data_bit_next;

  assign load      = (state_q == TX_IDLE) && DATA_VALID;
  assign active    = (state_q != TX_IDLE);
  assign data_step = (state_q == TX_DATA) && bit_done;

  uart_tx_serializer #(
    .data_width     (data_width),
    .prescale_width (prescale_width),
    .bit_cnt_width  (bit_cnt_width)
  ) u_serializer (
    .clk           (CLK),
    .rst_n         (RST),
    .load          (load),
    .active        (active),
    .data_step     (data_step),
    .p_data        (P_DATA),
    .par_typ       (PAR_TYP),
    .prescale      (prescale),
    .bit_done      (bit_done),
    .last_bit      (last_bit),
    .parity_bit    (parity_bit),
    .data_bit_next (data_bit_next)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= TX_IDLE;
      par_en_q <= 1'b0;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (load) begin
        par_en_q <= PAR_EN;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:   if (DATA_VALID) state_d = TX_START;
      TX_START:  if (bit_done)   state_d = TX_DATA;
      TX_DATA:   if (bit_done && last_bit) state_d = par_en_q ? TX_PARITY : TX_STOP;
      TX_PARITY: if (bit_done)   state_d = TX_STOP;
      TX_STOP:   if (bit_done)   state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops show the new bit
  // on the same edge the state changes.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      TX_START:  tx_d = START_BIT;
      TX_DATA:   tx_d = data_bit_next;
      TX_PARITY: tx_d = parity_bit;
      TX_STOP:   tx_d = STOP_BIT;
      default:   tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
